// File: rtl/data_mem_ctrl.sv
// Data-memory stage: word-addressed RAM behind a fixed wait-state latency, with a CPU stall handshake.
// Optional build macro MEM_MMIO_EN maps byte address 32'hFFFF_FFF0 onto the mmio_out register.
//
// state | meaning
// IDLE  | no access in flight; aligned request starts one, misaligned one flags MisalignErr
// WAIT  | wait states counting down on captured address/data/op
// DONE  | access completed on entry edge; ReadData valid, Stall released
module data_mem_ctrl #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr
`ifdef MEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic [31:0]           addr_q, data_q;
  logic                  wr_q;
  logic                  req, aligned, start, done_entry;
  logic [31:0]           cur_addr, cur_data;
  logic                  cur_wr;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  mmio_hit;
  logic [31:0]           mmio_val;
  logic                  unused_addr_bits;
  logic [31:0]           mem [DEPTH];

  assign req     = MemRead | MemWrite;
  assign aligned = (ALUResult[1:0] == 2'b00);

  // With zero wait states the access completes on the start edge, so live inputs are used.
  assign cur_addr = (state == ST_IDLE) ? ALUResult : addr_q;
  assign cur_data = (state == ST_IDLE) ? WriteData : data_q;
  assign cur_wr   = (state == ST_IDLE) ? MemWrite  : wr_q;
  assign idx      = cur_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{cur_addr[31:DEPTH_LOG2+2], cur_addr[1:0]};

`ifdef MEM_MMIO_EN
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;
  assign mmio_hit = (cur_addr == MMIO_ADDR);
  assign mmio_val = mmio_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_out <= '0;
    end else if (done_entry && cur_wr && mmio_hit) begin
      mmio_out <= cur_data;
    end
  end
`else
  assign mmio_hit = 1'b0;
  assign mmio_val = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    Stall       = 1'b0;
    MisalignErr = 1'b0;
    start       = 1'b0;
    done_entry  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (!aligned) begin
            MisalignErr = 1'b1;
          end else begin
            Stall = 1'b1;
            start = 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_nxt  = ST_DONE;
              done_entry = 1'b1;
            end else begin
              state_nxt = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        Stall = 1'b1;
        if (cnt == 4'd1) begin
          state_nxt  = ST_DONE;
          done_entry = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Reset must also block the RAM write that a zero-wait request would otherwise issue.
    if (!reset) begin
      Stall       = 1'b0;
      MisalignErr = 1'b0;
      start       = 1'b0;
      done_entry  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      addr_q <= ALUResult;
      data_q <= WriteData;
      wr_q   <= MemWrite;
      cnt    <= WAIT_INIT;
    end else if (state == ST_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (done_entry && cur_wr && !mmio_hit) begin
      mem[idx] <= cur_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData <= '0;
    end else if (done_entry && !cur_wr) begin
      ReadData <= mmio_hit ? mmio_val : mem[idx];
    end else if (state == ST_DONE) begin
      ReadData <= '0;
    end
  end

endmodule
